// File: rtl/mem_pkg.sv
// Shared widths and state encoding for the memory copy engine.
package mem_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    FIN   = 2'b11
  } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: one read cycle then one write cycle per word,
// with a running modulo-2^DATA_W checksum of the copied data.
module mem_copy_engine #(
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_pkg::DATA_W
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              WEn,
  input  logic [DATA_W-1:0] read_data
);

  import mem_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] data_reg_q, data_reg_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q    <= IDLE;
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      count_q    <= '0;
      data_reg_q <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      count_q    <= count_d;
      data_reg_q <= data_reg_d;
      checksum_q <= checksum_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    count_d    = count_q;
    data_reg_d = data_reg_q;
    checksum_d = checksum_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_ptr_d  = src;
          dst_ptr_d  = dst;
          count_d    = len;
          checksum_d = '0;
          state_d    = (len == '0) ? FIN : READ;
        end
      end
      READ: begin
        data_reg_d = read_data;
        checksum_d = checksum_q + read_data;
        state_d    = WRITE;
      end
      WRITE: begin
        // Pointers wrap naturally at the address width.
        src_ptr_d = src_ptr_q + 1'b1;
        dst_ptr_d = dst_ptr_q + 1'b1;
        count_d   = count_q - 1'b1;
        state_d   = (count_q == ADDR_W'(1)) ? FIN : READ;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs depend only on registered state.
  always_comb begin
    address    = '0;
    write_data = '0;
    WEn        = 1'b0;
    unique case (state_q)
      READ: address = src_ptr_q;
      WRITE: begin
        address    = dst_ptr_q;
        write_data = data_reg_q;
        WEn        = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign checksum = checksum_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: negedge 4K x 16 memory responder, transaction-level
// per-cycle model, and directed scenarios with literal expectations.
module tb_mem_copy_engine;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic        start = 1'b0;
  logic [11:0] src = '0;
  logic [11:0] dst = '0;
  logic [11:0] len = '0;
  logic        busy, done, WEn;
  logic [15:0] checksum, write_data;
  logic [11:0] address;
  logic [15:0] read_data;

  int checks = 0;
  int failures = 0;
  int wen_count = 0;

  logic [15:0] mem   [4096];
  logic [15:0] m_mem [4096];

  always #5 Clk = ~Clk;

  mem_copy_engine #(.ADDR_W(12), .DATA_W(16)) dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .start      (start),
    .src        (src),
    .dst        (dst),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum),
    .address    (address),
    .write_data (write_data),
    .WEn        (WEn),
    .read_data  (read_data)
  );

  // Memory responder acting on the falling edge.
  always @(negedge Clk) begin
    if (WEn === 1'b1) begin
      mem[address] <= write_data;
      wen_count    <= wen_count + 1;
    end else begin
      read_data <= mem[address];
    end
  end

  // Transaction model: cycle k of an accepted copy of N words is a read of word (k-1)/2
  // when k is odd, a write of word k/2-1 when k is even, and done at k = 2N+1.
  bit          armed = 1'b0;
  int          m_k = 0;
  logic [11:0] m_src, m_dst, m_len;
  logic [15:0] m_sum = '0;
  logic [15:0] m_data = '0;

  always @(posedge Clk) begin
    logic        s_start;
    logic [11:0] s_src, s_dst, s_len, e_addr;
    logic [15:0] e_wd;
    logic        e_busy, e_done, e_wen;
    int          i;
    s_start = start;
    s_src   = src;
    s_dst   = dst;
    s_len   = len;
    if (!nReset) begin
      armed = 1'b1;
      m_k   = 0;
      m_sum = '0;
    end else if (m_k == 0) begin
      if (s_start) begin
        m_k   = 1;
        m_src = s_src;
        m_dst = s_dst;
        m_len = s_len;
        m_sum = '0;
      end
    end else if (m_k >= 2 * int'(m_len) + 1) begin
      m_k = 0;
    end else begin
      m_k++;
    end
    #1;
    if (armed) begin
      e_busy = (m_k != 0);
      e_done = (m_k != 0) && (m_k == 2 * int'(m_len) + 1);
      e_wen  = 1'b0;
      e_addr = '0;
      e_wd   = '0;
      if (m_k != 0 && m_k <= 2 * int'(m_len)) begin
        if (m_k % 2 == 1) begin
          i      = (m_k - 1) / 2;
          e_addr = m_src + 12'(i);
        end else begin
          i      = m_k / 2 - 1;
          e_addr = m_dst + 12'(i);
          e_wen  = 1'b1;
          e_wd   = m_data;
        end
      end
      checks++;
      if ({busy, done, WEn, address, write_data, checksum} !==
          {e_busy, e_done, e_wen, e_addr, e_wd, m_sum}) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t k=%0d actual busy=%b done=%b wen=%b addr=%h wd=%h sum=%h required busy=%b done=%b wen=%b addr=%h wd=%h sum=%h",
                 $time, m_k, busy, done, WEn, address, write_data, checksum,
                 e_busy, e_done, e_wen, e_addr, e_wd, m_sum);
      end
      if (m_k != 0 && m_k <= 2 * int'(m_len)) begin
        if (m_k % 2 == 1) begin
          m_data = m_mem[e_addr];
          m_sum  = m_sum + m_data;
        end else begin
          m_mem[e_addr] = m_data;
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] v);
    mem[a]   = v;
    m_mem[a] = v;
  endtask

  // Leaves the bench in cycle 1 after the start posedge.
  task automatic do_start(input logic [11:0] s, input logic [11:0] d, input logic [11:0] l);
    src   = s;
    dst   = d;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int done_cyc, output int busy_cyc);
    done_cyc = -1;
    busy_cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int dc, bc, w0;
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, bc, w0;
    for (int a = 0; a < 4096; a++) begin
      mem[a]   = '0;
      m_mem[a] = '0;
    end
    for (int a = 0; a < 4; a++) poke(12'h010 + 12'(a), 16'(a + 1));
    nReset = 1'b0;
    repeat (2) tick();
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_wen", int'(WEn), 0);
    check("reset_addr", int'(address), 0);
    check("reset_checksum", int'(checksum), 0);
    nReset = 1'b1;

    // Basic, started on the first posedge after reset release.
    do_start(12'h010, 12'h100, 12'd4);
    wait_done(dc, bc);
    check("basic_done_cycle", dc, 9);
    check("basic_busy_cycles", bc, 9);
    tick();
    for (int a = 0; a < 4; a++) check("basic_dst_word", int'(mem[12'h100 + 12'(a)]), a + 1);
    check("basic_checksum", int'(checksum), 16'h000A);
    check("basic_model_sum", int'(m_sum), 16'h000A);

    // len = 0
    w0 = wen_count;
    do_start(12'h050, 12'h060, 12'd0);
    wait_done(dc, bc);
    check("len0_done_cycle", dc, 1);
    tick();
    check("len0_no_write", wen_count - w0, 0);
    check("len0_checksum", int'(checksum), 0);

    // Wrap: 0xAAAA + 0xBBBB + 0xCCCC = 0x23331, so the 16-bit sum is 0x3331.
    poke(12'hFFE, 16'hAAAA);
    poke(12'hFFF, 16'hBBBB);
    poke(12'h000, 16'hCCCC);
    do_start(12'hFFE, 12'h7FF, 12'd3);
    wait_done(dc, bc);
    check("wrap_done_cycle", dc, 7);
    tick();
    check("wrap_dst_7ff", int'(mem[12'h7FF]), 16'hAAAA);
    check("wrap_dst_800", int'(mem[12'h800]), 16'hBBBB);
    check("wrap_dst_801", int'(mem[12'h801]), 16'hCCCC);
    check("wrap_checksum", int'(checksum), 16'h3331);
    check("wrap_model_sum", int'(m_sum), 16'h3331);

    // Overlap: each written word is re-read as the next source.
    poke(12'h020, 16'h0005);
    for (int a = 1; a <= 3; a++) poke(12'h020 + 12'(a), 16'hDEAD);
    do_start(12'h020, 12'h021, 12'd3);
    wait_done(dc, bc);
    tick();
    for (int a = 1; a <= 3; a++) check("overlap_dst_word", int'(mem[12'h020 + 12'(a)]), 5);
    check("overlap_checksum", int'(checksum), 16'h000F);

    // Start while busy is ignored.
    for (int a = 0; a < 4; a++) poke(12'h030 + 12'(a), 16'(17 * (a + 1)));
    poke(12'h200, 16'h0099);
    poke(12'h201, 16'h0099);
    poke(12'h400, 16'hDEAD);
    poke(12'h401, 16'hDEAD);
    do_start(12'h030, 12'h300, 12'd4);
    tick();
    tick();
    src   = 12'h200;
    dst   = 12'h400;
    len   = 12'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(dc, bc);
    check("busy_start_done_cycle", dc, 6);
    tick();
    for (int a = 0; a < 4; a++)
      check("busy_start_first_dst", int'(mem[12'h300 + 12'(a)]), 17 * (a + 1));
    check("busy_start_ignored_400", int'(mem[12'h400]), 16'hDEAD);
    check("busy_start_ignored_401", int'(mem[12'h401]), 16'hDEAD);
    check("busy_start_checksum", int'(checksum), 16'h00AA);
    check("busy_start_idle_after", int'(busy), 0);

    // Reset lands on the posedge that would begin the third WRITE of a len=5 copy.
    for (int a = 0; a < 5; a++) begin
      poke(12'h040 + 12'(a), 16'(16'h0101 + a));
      poke(12'h500 + 12'(a), 16'hDEAD);
    end
    do_start(12'h040, 12'h500, 12'd5);
    repeat (4) tick();
    nReset = 1'b0;
    tick();
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_wen", int'(WEn), 0);
    check("abort_word0", int'(mem[12'h500]), 16'h0101);
    check("abort_word1", int'(mem[12'h501]), 16'h0102);
    check("abort_word2", int'(mem[12'h502]), 16'hDEAD);
    nReset = 1'b1;
    do_start(12'h010, 12'h600, 12'd1);
    wait_done(dc, bc);
    check("after_abort_done_cycle", dc, 3);
    tick();
    check("after_abort_word", int'(mem[12'h600]), 1);
    check("after_abort_checksum", int'(checksum), 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
